// File: rtl/triangle_point_sink_if.sv
// rtl/triangle_point_sink_if.sv - rasteriser point stream in, seven-segment digit codes out
interface triangle_point_sink_if;
    logic       busy;
    logic       po;
    logic [2:0] xi;
    logic [2:0] yi;
    logic [3:0] dig_x;
    logic [3:0] dig_y;
    logic [6:0] pt_count;
    logic       done;
    logic       ovf;

    modport master (
        output busy, po, xi, yi,
        input  dig_x, dig_y, pt_count, done, ovf
    );

    modport slave (
        input  busy, po, xi, yi,
        output dig_x, dig_y, pt_count, done, ovf
    );
endinterface

// File: rtl/triangle_point_sink.sv
// rtl/triangle_point_sink.sv - buffers one triangle's points and replays them for HOLD cycles each
module triangle_point_sink #(
    parameter int DEPTH = 64,
    parameter int HOLD  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    triangle_point_sink_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = $clog2(HOLD + 1);
    localparam logic [6:0]    DEPTH_C   = 7'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          busy_d_q;
    logic [6:0]    pt_count_q, pt_count_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic [3:0]    dig_x_q, dig_x_d, dig_y_q, dig_y_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [5:0]    mem_q [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0]    rd_data;
    logic          start;

    assign start   = bus.busy & ~busy_d_q;
    assign rd_data = mem_q[rd_q];

    // Digit/done outputs follow the current state only, so they lag a state change by one edge.
    always_comb begin
        state_d    = state_q;
        pt_count_d = pt_count_q;
        ovf_d      = ovf_q;
        rd_d       = rd_q;
        hold_d     = hold_q;
        wr_en      = 1'b0;
        wr_addr    = pt_count_q[AW-1:0];
        dig_x_d    = 4'hF;
        dig_y_d    = 4'hF;
        done_d     = 1'b0;

        case (state_q)
            S_CAPTURE: begin
                if (bus.po) begin
                    if (pt_count_q < DEPTH_C) begin
                        wr_en      = 1'b1;
                        pt_count_d = pt_count_q + 7'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (!bus.busy) begin
                    state_d = (pt_count_d != 7'd0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                dig_x_d = {1'b0, rd_data[5:3]};
                dig_y_d = {1'b0, rd_data[2:0]};
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    rd_d   = rd_q + 1'b1;
                    if (7'(rd_q) == pt_count_q - 7'd1) begin
                        state_d = S_DONE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase

        // A new triangle preempts whatever was in progress, replay included.
        if (start) begin
            state_d    = S_CAPTURE;
            ovf_d      = 1'b0;
            rd_d       = '0;
            hold_d     = '0;
            wr_addr    = '0;
            wr_en      = bus.po;
            pt_count_d = bus.po ? 7'd1 : 7'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            busy_d_q   <= 1'b0;
            pt_count_q <= 7'd0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            dig_x_q    <= 4'hF;
            dig_y_q    <= 4'hF;
            rd_q       <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_d_q   <= bus.busy;
            pt_count_q <= pt_count_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            dig_x_q    <= dig_x_d;
            dig_y_q    <= dig_y_d;
            rd_q       <= rd_d;
            hold_q     <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {bus.xi, bus.yi};
        end
    end

    assign bus.dig_x    = dig_x_q;
    assign bus.dig_y    = dig_y_q;
    assign bus.pt_count = pt_count_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_triangle_point_sink.sv
// tb/tb_triangle_point_sink.sv - directed checks of capture, replay timing, overflow, restart and reset
module tb_triangle_point_sink;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic [5:0] exp_q[$];

    triangle_point_sink_if tpi ();

    triangle_point_sink #(.DEPTH(64), .HOLD(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (tpi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic b, input logic p, input logic [2:0] x, input logic [2:0] y);
        tpi.busy = b;
        tpi.po   = p;
        tpi.xi   = x;
        tpi.yi   = y;
        tick();
    endtask

    // Called just after the busy-low edge; walks every hold cycle, then the done edge.
    task automatic expect_replay();
        logic [5:0] e;
        for (int j = 0; j < exp_q.size(); j++) begin
            e = exp_q[j];
            for (int h = 0; h < 4; h++) begin
                tick();
                check("rep_dig", {tpi.dig_x, tpi.dig_y}, {1'b0, e[5:3], 1'b0, e[2:0]});
                check("rep_done", tpi.done, 1'b0);
            end
        end
        tick();
        check("end_done", tpi.done, 1'b1);
        check("end_dig", {tpi.dig_x, tpi.dig_y}, 8'hFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] v;
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b0;
        tpi.busy = 1'b0;
        tpi.po   = 1'b0;
        tpi.xi   = 3'd0;
        tpi.yi   = 3'd0;

        // reset, then idle
        repeat (3) tick();
        check("rst_dig", {tpi.dig_x, tpi.dig_y}, 8'hFF);
        check("rst_cnt", tpi.pt_count, 7'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_dig", {tpi.dig_x, tpi.dig_y}, 8'hFF);
            check("idle_cnt", tpi.pt_count, 7'd0);
            check("idle_done", tpi.done, 1'b0);
            check("idle_ovf", tpi.ovf, 1'b0);
        end

        // three-point triangle
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 2);
        check("t3_cnt1", tpi.pt_count, 7'd1);
        cyc(1, 1, 2, 3);
        cyc(1, 1, 3, 1);
        check("t3_capdig", {tpi.dig_x, tpi.dig_y}, 8'hFF);
        cyc(0, 0, 0, 0);
        check("t3_cnt", tpi.pt_count, 7'd3);
        exp_q = {6'o12, 6'o23, 6'o31};
        expect_replay();

        // points on the busy-rise and busy-fall cycles
        cyc(1, 1, 5, 6);
        check("edge_cnt1", tpi.pt_count, 7'd1);
        cyc(1, 1, 7, 0);
        check("edge_done0", tpi.done, 1'b0);
        check("edge_dig", {tpi.dig_x, tpi.dig_y}, 8'hFF);
        cyc(0, 1, 4, 4);
        check("edge_cnt", tpi.pt_count, 7'd3);
        exp_q = {6'o56, 6'o70, 6'o44};
        expect_replay();

        // overflow: 70 consecutive points
        cyc(1, 0, 0, 0);
        exp_q.delete();
        for (int i = 0; i < 70; i++) begin
            v = 6'(i * 37 + 11);
            cyc(1, 1, v[5:3], v[2:0]);
            if (i < 64) exp_q.push_back(v);
            check("ovf_cnt", tpi.pt_count, (i < 64) ? i + 1 : 64);
            check("ovf_flag", tpi.ovf, (i >= 64) ? 1 : 0);
        end
        cyc(0, 0, 0, 0);
        check("ovf_cnt_end", tpi.pt_count, 7'd64);
        check("ovf_sticky", tpi.ovf, 1'b1);
        expect_replay();

        // restart during replay of entry 1 of 5
        cyc(1, 0, 0, 0);
        check("rs_ovf_clr", tpi.ovf, 1'b0);
        check("rs_cnt0", tpi.pt_count, 7'd0);
        cyc(1, 1, 4, 5);
        cyc(1, 1, 5, 4);
        cyc(1, 1, 6, 7);
        cyc(1, 1, 7, 0);
        cyc(1, 1, 0, 1);
        cyc(0, 0, 0, 0);
        check("rs_cnt5", tpi.pt_count, 7'd5);
        for (int h = 0; h < 4; h++) begin
            tick();
            check("rs_e0", {tpi.dig_x, tpi.dig_y}, 8'h45);
        end
        tick();
        check("rs_e1", {tpi.dig_x, tpi.dig_y}, 8'h54);
        cyc(1, 1, 6, 6);
        check("rs_cnt1", tpi.pt_count, 7'd1);
        cyc(1, 1, 2, 5);
        check("rs_blank", {tpi.dig_x, tpi.dig_y}, 8'hFF);
        check("rs_done", tpi.done, 1'b0);
        check("rs_cnt2", tpi.pt_count, 7'd2);
        cyc(1, 1, 7, 7);
        cyc(0, 0, 0, 0);
        check("rs_cnt3", tpi.pt_count, 7'd3);
        exp_q = {6'o66, 6'o25, 6'o77};
        expect_replay();

        // empty triangle
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("empty_cnt", tpi.pt_count, 7'd0);
        check("empty_done0", tpi.done, 1'b0);
        exp_q.delete();
        expect_replay();

        // asynchronous reset mid-capture
        cyc(1, 1, 3, 3);
        cyc(1, 1, 2, 2);
        check("ar_cnt", tpi.pt_count, 7'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_dig", {tpi.dig_x, tpi.dig_y}, 8'hFF);
        check("ar_cnt0", tpi.pt_count, 7'd0);
        check("ar_done", tpi.done, 1'b0);
        check("ar_ovf", tpi.ovf, 1'b0);
        tpi.busy = 1'b0;
        tpi.po   = 1'b0;
        tick();
        rst_n = 1'b1;
        cyc(0, 1, 1, 1);
        cyc(0, 1, 2, 2);
        check("ar_idle_po", tpi.pt_count, 7'd0);
        check("ar_idle_dig", {tpi.dig_x, tpi.dig_y}, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/triangle_point_sink.md
# triangle_point_sink

Collects the point stream produced by the triangle rasteriser (`po`/`xo`/`yo` while `busy` is high) and buffers up to DEPTH points per triangle. After `busy` falls, it replays the buffered points one at a time, holding each for HOLD clock cycles, as 4-bit digit codes for the seven-segment driver. It sits between the rasteriser outputs and the display digit inputs, in the `count_clk` domain, replacing direct display of the transient `po` stream.

## Interface
Parameters:
- DEPTH, 64: point buffer entries; must be a power of two ≤ 64.
- HOLD, 4: clock cycles each replayed point is displayed (≥ 1).

Ports:
- clk  in  1  system clock for the block (`count_clk` domain); all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- busy  in  1  rasteriser busy; high for the whole duration of one triangle.
- po  in  1  point valid; one point per cycle when high.
- xi  in  3  point x coordinate, valid when `po`=1.
- yi  in  3  point y coordinate, valid when `po`=1.
- dig_x  out  4  `{1'b0, x}` of the point being shown; 4'hF (blank) otherwise.
- dig_y  out  4  `{1'b0, y}` of the point being shown; 4'hF otherwise.
- pt_count  out  7  points stored for the current or last triangle (0..DEPTH).
- done  out  1  high while replay is complete and the block is waiting for a new triangle.
- ovf  out  1  sticky; set when a point arrived with the buffer full.

## Operation
- Internal `busy_d` holds `busy` registered. `start` = `busy & ~busy_d`.
- States: IDLE, CAPTURE, DRAIN, DONE.
- **`start` in any state** (including mid-DRAIN): takes priority over all other transitions.
  - Write pointer, `pt_count` and `ovf` clear; read index clears; state becomes CAPTURE.
  - If `po`=1 in the same cycle, that point is written as entry 0 and `pt_count` becomes 1.
- **CAPTURE:**
  - `po`=1 with `pt_count` < DEPTH: write `{xi,yi}` at the write pointer, then increment the pointer and `pt_count`.
  - `po`=1 with `pt_count` = DEPTH: drop the point and set `ovf`.
  - `busy`=0: a `po` in that cycle is still captured. Next state is DRAIN if the resulting `pt_count` > 0, else DONE.
- **DRAIN:**
  - Shows entry `rd` for HOLD cycles using a hold counter, then increments `rd`.
  - After the hold of entry `pt_count`-1 expires, next state is DONE.
  - `po` is ignored.
- **DONE:** `dig_x`/`dig_y` = 4'hF, `done`=1; stays until `start`.
- **IDLE:** entered only from reset; `po` is ignored; exits on `start`.
- Arithmetic:
  - `pt_count` is 7 bits and saturates at DEPTH.
  - Pointers are log2(DEPTH) bits; no wrap occurs because capture stops at full.
  - The hold counter is $clog2(HOLD+1) bits.
- Reset mid-operation returns to IDLE immediately. Buffer contents are don't-care after reset.

## Timing
- Reset values:
  - state IDLE, `busy_d`=0
  - `dig_x`=`dig_y`=4'hF
  - `pt_count`=0, `done`=0, `ovf`=0
- All outputs are registered; none is combinational from inputs.
- A `po` sampled at edge k:
  - `pt_count` reflects it from edge k.
  - `ovf` rises at edge k on a dropped point.
- With `busy` sampled 0 at edge k (state becomes DRAIN), `dig_x`/`dig_y` show entry 0 from edge k+1 through edge k+HOLD.
- Entry j is shown from edge k+1+j·HOLD.
- `done` rises at edge k+1+pt_count·HOLD. Blank digits appear on the same edge.
- A triangle with zero points: `done` rises at edge k+1.
- On `start` at edge m:
  - `dig_x`/`dig_y` = 4'hF and `done`=0 from edge m+1.
  - They remain so through CAPTURE.
- Sustained `po` every cycle is accepted with no back-pressure; the block never stalls the rasteriser.

## Test plan
- **Reset, then idle:** apply reset, then hold `busy`=`po`=0 for 20 cycles -> outputs F/F, count 0, `done`=0, `ovf`=0 throughout.
- **Three-point triangle, HOLD=4:**
  - Stimulus: `busy` high, `po` pulses (1,2), (2,3), (3,1), then `busy` low.
  - Required: `pt_count`=3; digits 1/2, 2/3, 3/1 each shown exactly 4 cycles; `done` rises 13 cycles after the `busy`-low edge.
- **Point coincident with `busy` edges:** `po` in the `start` cycle and in the `busy`-fall cycle -> both captured as the first and last entries.
- **Overflow, DEPTH=64:**
  - Stimulus: 70 consecutive `po`.
  - Required: `pt_count`=64; `ovf`=1 from the 65th point; replay shows exactly the first 64 points in order.
- **Restart mid-DRAIN:**
  - Stimulus: `busy` rises during replay of entry 1 of 5.
  - Required: digits blank next cycle, `pt_count` restarts from the new `po`s, `ovf` cleared, old points never reappear.
- **Empty triangle, then async reset mid-CAPTURE:**
  - Stimulus: a `busy` pulse with no `po`, then reset asserted during a later CAPTURE.
  - Required: `done` one cycle after the fall; after reset, all outputs return to reset values immediately with no clock.
